// File: rtl/fetch_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
// The master side issues the address; the slave side answers with data and ready.
interface fetch_if #(
  parameter int N = 64
) ();
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, imem request/ready handshake and IF/ID register.
// Priority each cycle: reset > redirect > stall > memory ready.
module fetch #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP      = 32'hD503201F
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall_F,
  input  logic         pcSrc_F,
  input  logic [N-1:0] pcBranch_F,
  fetch_if.master      imem,
  output logic [31:0]  instr_D,
  output logic [N-1:0] pc_D,
  output logic         valid_D
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_INC     = {{(N-3){1'b0}}, 3'b100};
  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  state_t       state_r, state_s;
  logic [N-1:0] pc_r, pc_s;
  logic [N-1:0] pc_d_r, pc_d_s;
  logic [31:0]  instr_r, instr_s;
  logic         valid_r, valid_s;
  logic         req_r, req_s;

  // Next-state, next-PC and IF/ID update; everything holds unless a rule below fires.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    pc_d_s  = pc_d_r;
    instr_s = instr_r;
    valid_s = valid_r;
    if (pcSrc_F) begin
      // Redirect wins over stall and ready; any returning data is dropped.
      state_s = FETCH;
      pc_s    = pcBranch_F & ALIGN_MASK;
      instr_s = NOP;
      pc_d_s  = {N{1'b0}};
      valid_s = 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_s = FETCH;
        end
        FETCH, WAIT: begin
          if (stall_F) begin
            state_s = state_r;
          end else if (req_r && imem.imem_ready) begin
            state_s = FETCH;
            pc_s    = pc_r + PC_INC;
            instr_s = imem.imem_rdata;
            pc_d_s  = pc_r;
            valid_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s = BOOT;
        end
      endcase
    end
    req_s = (state_s != BOOT);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      instr_r <= NOP;
      pc_d_r  <= {N{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      req_r   <= req_s;
      instr_r <= instr_s;
      pc_d_r  <= pc_d_s;
      valid_r <= valid_s;
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign instr_D        = instr_r;
  assign pc_D           = pc_d_r;
  assign valid_D        = valid_r;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: boot, stall, wait states, redirect, PC wrap and async reset.
module tb_fetch;
  localparam int          N   = 64;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic         clk;
  logic         reset_n;
  logic         stall_F;
  logic         pcSrc_F;
  logic [N-1:0] pcBranch_F;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;

  int vec_cnt = 0;
  int err_cnt = 0;

  fetch_if #(.N(N)) imem ();

  fetch #(.N(N), .RESET_PC(64'h0), .NOP(NOP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_F    (stall_F),
    .pcSrc_F    (pcSrc_F),
    .pcBranch_F (pcBranch_F),
    .imem       (imem.master),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D)
  );

  // Memory returns a word derived from the address it is given.
  assign imem.imem_rdata = imem.imem_addr[31:0] ^ 32'h5A5A0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [N-1:0] a);
    return a[31:0] ^ 32'h5A5A0000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [N-1:0] addr,
                           input logic valid, input logic [N-1:0] pcd, input logic [31:0] ins);
    check_val({tag, ".req"},   64'(imem.imem_req), 64'(req));
    check_val({tag, ".addr"},  imem.imem_addr,     addr);
    check_val({tag, ".valid"}, 64'(valid_D),       64'(valid));
    check_val({tag, ".pc_D"},  pc_D,               pcd);
    check_val({tag, ".instr"}, 64'(instr_D),       64'(ins));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    stall_F         = 1'b0;
    pcSrc_F         = 1'b0;
    pcBranch_F      = '0;
    imem.imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 64'h0, 1'b0, 64'h0, NOP);

    // Release between edges; the first edge only leaves BOOT.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("boot.req0", 64'(imem.imem_req), 64'h0);
    step(); check_all("boot.e1", 1'b1, 64'h0, 1'b0, 64'h0, NOP);
    step(); check_all("boot.e2", 1'b1, 64'h4, 1'b1, 64'h0, rd(64'h0));
    step(); check_all("boot.e3", 1'b1, 64'h8, 1'b1, 64'h4, rd(64'h4));
    step(); check_all("boot.e4", 1'b1, 64'hC, 1'b1, 64'h8, rd(64'h8));

    // Stall two cycles with ready high: everything frozen.
    stall_F = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); check_all("stall", 1'b1, 64'hC, 1'b1, 64'h8, rd(64'h8));
    end
    stall_F = 1'b0;
    step(); check_all("stall.rel", 1'b1, 64'h10, 1'b1, 64'hC, rd(64'hC));

    // Three wait cycles at 0x10.
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("wait", 1'b1, 64'h10, 1'b1, 64'hC, rd(64'hC));
    end
    check_val("wait.state", 64'(dut.state_r), 64'd2);
    imem.imem_ready = 1'b1;
    step(); check_all("wait.rel", 1'b1, 64'h14, 1'b1, 64'h10, rd(64'h10));

    // Redirect while in WAIT and stalled.
    imem.imem_ready = 1'b0;
    step(); check_all("wait2", 1'b1, 64'h14, 1'b1, 64'h10, rd(64'h10));
    pcSrc_F    = 1'b1;
    pcBranch_F = 64'h103;
    stall_F    = 1'b1;
    step(); check_all("redir", 1'b1, 64'h100, 1'b0, 64'h0, NOP);
    check_val("redir.state", 64'(dut.state_r), 64'd1);
    pcSrc_F         = 1'b0;
    stall_F         = 1'b0;
    imem.imem_ready = 1'b1;
    step(); check_all("redir.tgt", 1'b1, 64'h104, 1'b1, 64'h100, rd(64'h100));

    // Wrap from 2^N-4 to 0.
    pcSrc_F    = 1'b1;
    pcBranch_F = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); check_all("wrap.redir", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, NOP);
    pcSrc_F = 1'b0;
    step(); check_all("wrap.acc", 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, rd(64'hFFFF_FFFF_FFFF_FFFC));
    step(); check_all("wrap.next", 1'b1, 64'h4, 1'b1, 64'h0, rd(64'h0));

    // Asynchronous reset in the middle of a WAIT cycle.
    imem.imem_ready = 1'b0;
    step(); check_all("wait3", 1'b1, 64'h4, 1'b1, 64'h0, rd(64'h0));
    #2;
    reset_n = 1'b0;
    #1;
    check_all("areset", 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    check_val("areset.state", 64'(dut.state_r), 64'd0);
    @(negedge clk);
    reset_n         = 1'b1;
    imem.imem_ready = 1'b1;
    step(); check_all("restart.e1", 1'b1, 64'h0, 1'b0, 64'h0, NOP);
    step(); check_all("restart.e2", 1'b1, 64'h4, 1'b1, 64'h0, rd(64'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
